// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA burst writer.
// Holds the FSM encoding and the burst-length minimum.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    XFER,
    DONE
  } state_e;

  localparam int MAX_BURST_DEF = 8;
  localparam int BURST_WD = $clog2(MAX_BURST_DEF) + 1;

  function automatic int unsigned burst_min(
    input int unsigned rem,
    input int unsigned room
  );
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length for the next burst: limited by remaining beats
// and by the distance to the next MAX_BURST-aligned boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int ADDR_WD   = 16,
  parameter int LEN_WD    = 12,
  parameter int MAX_BURST = 8,
  parameter int BW        = $clog2(MAX_BURST) + 1
) (
  input  logic [ADDR_WD-1:0] cur_addr,
  input  logic [LEN_WD-1:0]  remaining,
  output logic [BW-1:0]      burst_len
);

  localparam int OW = $clog2(MAX_BURST);

  logic [OW-1:0] offs;
  logic [BW-1:0] room;

  assign offs = cur_addr[OW-1:0];
  assign room = BW'(MAX_BURST) - BW'(offs);
  assign burst_len =
    BW'(burst_min(32'(remaining), 32'(room)));

endmodule

// File: rtl/dma_burst_writer.sv
// Drains the stream FIFO into boundary-safe write bursts,
// one descriptor at a time.
module dma_burst_writer
  import dma_pkg::*;
#(
  parameter int DATA_WD   = 32,
  parameter int ADDR_WD   = 16,
  parameter int LEN_WD    = 12,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [ADDR_WD-1:0] desc_addr,
  input  logic [LEN_WD-1:0]  desc_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_WD-1:0] s_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_WD-1:0] wr_addr,
  output logic [DATA_WD-1:0] wr_data,
  output logic               wr_last,
  output logic               busy,
  output logic               done
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WD-1:0]  remaining_q, remaining_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]      burst_len;

  dma_burst_calc #(
    .ADDR_WD   (ADDR_WD),
    .LEN_WD    (LEN_WD),
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_calc (
    .cur_addr  (cur_addr_q),
    .remaining (remaining_q),
    .burst_len (burst_len)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    desc_ready  = 1'b0;
    wr_valid    = 1'b0;
    s_ready     = 1'b0;
    wr_last     = 1'b0;
    done        = 1'b0;
    wr_addr     = cur_addr_q;
    wr_data     = s_data;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          cur_addr_d  = desc_addr;
          remaining_d = desc_len;
          state_d = (desc_len != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        beat_cnt_d = burst_len;
        state_d    = XFER;
      end
      XFER: begin
        wr_valid = s_valid;
        s_ready  = wr_ready;
        wr_last  = (beat_cnt_q == BW'(1));
        // A beat moves only when both sides agree
        if (s_valid && wr_ready) begin
          cur_addr_d  = cur_addr_q + ADDR_WD'(1);
          remaining_d = remaining_q - LEN_WD'(1);
          beat_cnt_d  = beat_cnt_q - BW'(1);
          if (wr_last) begin
            state_d = (remaining_q == LEN_WD'(1))
                    ? DONE : CALC;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_burst_writer.sv
// Scoreboard bench for dma_burst_writer: expected beats are
// queued per descriptor and popped as write beats fire.
module tb_dma_burst_writer;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 12;
  localparam int MB = 8;

  logic          clk;
  logic          rstn;
  logic          desc_valid;
  logic          desc_ready;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          busy;
  logic          done;

  dma_burst_writer #(
    .DATA_WD   (DW),
    .ADDR_WD   (AW),
    .LEN_WD    (LW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_len   (desc_len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         sb[$];
  int            fire_cyc[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            fire_cnt = 0;
  int            vld_cnt = 0;
  int            acc_cyc = 0;
  int            done_cyc = 0;
  bit            bp_mode = 0;
  logic [DW-1:0] src_data;
  logic [DW-1:0] data_next;

  assign s_data = src_data;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // FIFO source model plus write-port monitor
  initial begin
    bit    fire;
    beat_t e;
    s_valid  = 1'b0;
    wr_ready = 1'b0;
    src_data = 32'hA000_0000;
    forever begin
      @(negedge clk);
      cyc++;
      fire = wr_valid && wr_ready;
      if (desc_valid && desc_ready) acc_cyc = cyc;
      if (wr_valid) vld_cnt++;
      if (!wr_ready) check("s_ready_bp", 64'(s_ready), 0);
      if (fire) begin
        fire_cnt++;
        fire_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("addr", 64'(wr_addr), 64'(e.a));
          check("data", 64'(wr_data), 64'(e.d));
          check("last", 64'(wr_last), 64'(e.l));
        end
      end
      @(posedge clk);
      #1;
      if (fire) src_data = src_data + 1;
      if (bp_mode) begin
        wr_ready = !wr_ready;
        s_valid  = ($urandom_range(0, 3) != 0);
      end else begin
        wr_ready = 1'b1;
        s_valid  = 1'b1;
      end
    end
  end

  task automatic push_model(
    input logic [AW-1:0] addr,
    input int            len
  );
    logic [AW-1:0] a;
    int            rem;
    int            room;
    int            b;
    beat_t         e;
    a   = addr;
    rem = len;
    while (rem > 0) begin
      room = MB - (int'(a) % MB);
      b    = (rem < room) ? rem : room;
      for (int i = 0; i < b; i++) begin
        e.a = a;
        e.d = data_next;
        e.l = (i == b - 1);
        sb.push_back(e);
        a = a + 1'b1;
        data_next = data_next + 1;
      end
      rem -= b;
    end
  endtask

  task automatic send_desc(
    input logic [AW-1:0] addr,
    input int            len
  );
    int n;
    push_model(addr, len);
    @(posedge clk);
    #1;
    desc_valid = 1'b1;
    desc_addr  = addr;
    desc_len   = LW'(len);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!desc_ready && n < 50);
    check("accept_timeout", 64'(desc_ready), 1);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    desc_addr  = AW'($urandom);
    desc_len   = LW'($urandom);
  endtask

  task automatic wait_done();
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (n < 2000 && !ok) begin
      @(negedge clk);
      #1;
      n++;
      if (done) ok = 1;
    end
    check("done_timeout", 64'(ok), 1);
    done_cyc = cyc;
    check("done_rdy_low", 64'(desc_ready), 0);
    @(negedge clk);
    #1;
    check("done_pulse", 64'(done), 0);
    check("idle_ready", 64'(desc_ready), 1);
    check("idle_busy", 64'(busy), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_desc_ready"}, 64'(desc_ready), 1);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_wr_valid"}, 64'(wr_valid), 0);
    check({tag, "_s_ready"}, 64'(s_ready), 0);
    check({tag, "_wr_last"}, 64'(wr_last), 0);
  endtask

  initial begin
    int f0;
    int v0;
    int n;
    rstn       = 1'b0;
    desc_valid = 1'b0;
    desc_addr  = '0;
    desc_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    @(negedge clk);
    rstn = 1'b1;
    data_next = src_data;

    // Aligned: two full bursts, one bubble
    fire_cyc.delete();
    f0 = fire_cnt;
    send_desc(16'h0010, 16);
    wait_done();
    check("al_beats", 64'(fire_cnt - f0), 16);
    check("al_sb_empty", 64'(sb.size()), 0);
    if (fire_cyc.size() == 16) begin
      check("al_lat", 64'(fire_cyc[0] - acc_cyc), 2);
      check("al_b1", 64'(fire_cyc[7] - fire_cyc[0]), 7);
      check("al_bubble", 64'(fire_cyc[8] - fire_cyc[7]), 2);
      check("al_done", 64'(done_cyc - fire_cyc[15]), 1);
    end

    // Unaligned: 3 + 7
    fire_cyc.delete();
    f0 = fire_cnt;
    send_desc(16'h0005, 10);
    wait_done();
    check("un_beats", 64'(fire_cnt - f0), 10);
    check("un_sb_empty", 64'(sb.size()), 0);
    if (fire_cyc.size() == 10)
      check("un_bubble", 64'(fire_cyc[3] - fire_cyc[2]), 2);

    // Backpressure on both sides
    bp_mode = 1;
    f0 = fire_cnt;
    send_desc(16'h0000, 8);
    wait_done();
    bp_mode = 0;
    check("bp_beats", 64'(fire_cnt - f0), 8);
    check("bp_sb_empty", 64'(sb.size()), 0);
    repeat (2) @(posedge clk);

    // Zero length
    v0 = vld_cnt;
    send_desc(16'h0030, 0);
    wait_done();
    check("zl_no_valid", 64'(vld_cnt - v0), 0);
    check("zl_done_lat", 64'(done_cyc - acc_cyc), 1);

    // Address wrap
    f0 = fire_cnt;
    send_desc(16'hFFFC, 6);
    wait_done();
    check("wr_beats", 64'(fire_cnt - f0), 6);
    check("wr_sb_empty", 64'(sb.size()), 0);

    // Reset mid-burst
    f0 = fire_cnt;
    send_desc(16'h0040, 16);
    n = 0;
    while (fire_cnt - f0 < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rm_reach3", 64'(fire_cnt - f0), 3);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outs("rm");
    sb.delete();
    data_next = src_data;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rm_no_more", 64'(fire_cnt - f0), 3);
    check("rm_idle", 64'(busy), 0);
    f0 = fire_cnt;
    send_desc(16'h0123, 5);
    wait_done();
    check("rm_new_beats", 64'(fire_cnt - f0), 5);
    check("rm_sb_empty", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
